// File: rtl/sim_mailbox_bus_splitter_pkg.sv
// Shared definitions for the simulation mailbox bus splitter: mailbox offsets,
// bus order encodings, FSM states and the byte-swap helper.
package sim_mailbox_bus_splitter_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RDATA_W = 64;
    localparam int unsigned IDX_W   = 3;

    localparam logic [4:0] OFF_FLAG   = 5'h00;
    localparam logic [4:0] OFF_FINISH = 5'h04;
    localparam logic [4:0] OFF_TYPE   = 5'h08;
    localparam logic [4:0] OFF_INDEX  = 5'h0C;
    localparam logic [4:0] OFF_RESULT = 5'h10;
    localparam logic [4:0] OFF_EXPECT = 5'h14;

    localparam logic [1:0] ORDER_BYTE = 2'b00;
    localparam logic [1:0] ORDER_HALF = 2'b01;
    localparam logic [1:0] ORDER_WORD = 2'b10;
    localparam logic [1:0] ORDER_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Bus byte order <-> register byte order; the operation is its own inverse.
    function automatic logic [DATA_W-1:0] word_swap(input logic [DATA_W-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/sim_mailbox_regfile.sv
// Mailbox register file: decoded word writes, sticky done/pass/bus-error
// status and the bus-order read mux for the mailbox window.
module sim_mailbox_regfile
    import sim_mailbox_bus_splitter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               wr_word,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [RDATA_W-1:0] rd_data_c,
    output logic               done,
    output logic               pass,
    output logic               bus_err,
    output logic [DATA_W-1:0]  type_reg,
    output logic [DATA_W-1:0]  index_reg,
    output logic [DATA_W-1:0]  result_reg,
    output logic [DATA_W-1:0]  expect_reg
);

    logic              flag;
    logic [DATA_W-1:0] rd_word;

    // Word writes update registers until the finish word locks the mailbox.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            bus_err    <= 1'b0;
            type_reg   <= '0;
            index_reg  <= '0;
            result_reg <= '0;
            expect_reg <= '0;
        end else begin
            if (wr_en && !wr_word) begin
                bus_err <= 1'b1;
            end
            if (wr_en && wr_word && !done) begin
                case ({wr_idx, 2'b00})
                    OFF_FLAG:   flag <= wr_data[24];
                    OFF_FINISH: begin
                        done <= 1'b1;
                        pass <= flag;
                    end
                    OFF_TYPE:   type_reg   <= word_swap(wr_data);
                    OFF_INDEX:  index_reg  <= word_swap(wr_data);
                    OFF_RESULT: result_reg <= word_swap(wr_data);
                    OFF_EXPECT: expect_reg <= word_swap(wr_data);
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case ({rd_idx, 2'b00})
            OFF_FLAG:   rd_word = {7'b0, flag, 24'b0};
            OFF_FINISH: rd_word = {31'b0, done};
            OFF_TYPE:   rd_word = word_swap(type_reg);
            OFF_INDEX:  rd_word = word_swap(index_reg);
            OFF_RESULT: rd_word = word_swap(result_reg);
            OFF_EXPECT: rd_word = word_swap(expect_reg);
            default:    rd_word = '0;
        endcase
        rd_data_c = {rd_word, rd_word};
    end

endmodule

// File: rtl/sim_mailbox_bus_splitter.sv
// Splits core memory requests between the test-result mailbox window and
// downstream memory, tracking outstanding downstream reads for ordering.
module sim_mailbox_bus_splitter
    import sim_mailbox_bus_splitter_pkg::*;
#(
    parameter logic [31:0] PL_MBX_BASE        = 32'h0002_0000,
    parameter int unsigned PL_MAX_OUTSTANDING = 4
) (
    input  logic                iCLOCK,
    input  logic                iRESET_SYNC,
    input  logic                iMEMORY_REQ,
    output logic                oMEMORY_LOCK,
    input  logic [1:0]          iMEMORY_ORDER,
    input  logic [3:0]          iMEMORY_MASK,
    input  logic                iMEMORY_RW,
    input  logic [ADDR_W-1:0]   iMEMORY_ADDR,
    input  logic [DATA_W-1:0]   iMEMORY_DATA,
    output logic                oMEMORY_VALID,
    input  logic                iMEMORY_LOCK,
    output logic [RDATA_W-1:0]  oMEMORY_DATA,
    output logic                oMEM_REQ,
    output logic [1:0]          oMEM_ORDER,
    output logic [3:0]          oMEM_MASK,
    output logic                oMEM_RW,
    output logic [ADDR_W-1:0]   oMEM_ADDR,
    output logic [DATA_W-1:0]   oMEM_DATA,
    input  logic                iMEM_LOCK,
    input  logic                iMEM_VALID,
    output logic                oMEM_LOCK,
    input  logic [RDATA_W-1:0]  iMEM_DATA,
    output logic                oMBX_DONE,
    output logic                oMBX_PASS,
    output logic [DATA_W-1:0]   oMBX_TYPE,
    output logic [DATA_W-1:0]   oMBX_INDEX,
    output logic [DATA_W-1:0]   oMBX_RESULT,
    output logic [DATA_W-1:0]   oMBX_EXPECT,
    output logic                oMBX_BUS_ERR
);

    localparam int unsigned     CNT_W   = $clog2(PL_MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PL_MAX_OUTSTANDING);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    count;
    logic [IDX_W-1:0]    rd_idx;
    logic [RDATA_W-1:0]  mbx_rdata;
    logic                hit;
    logic                full_c;
    logic                accept;
    logic                ds_read;
    logic                mbx_wr;
    logic                mbx_rd;

    assign hit     = (iMEMORY_ADDR[31:5] == PL_MBX_BASE[31:5]);
    assign full_c  = !iMEMORY_RW && (count == CNT_MAX);
    assign accept  = iMEMORY_REQ && !oMEMORY_LOCK;
    assign ds_read = accept && !hit && !iMEMORY_RW;
    assign mbx_wr  = accept && hit && iMEMORY_RW;
    assign mbx_rd  = accept && hit && !iMEMORY_RW;

    assign oMEM_ORDER = iMEMORY_ORDER;
    assign oMEM_MASK  = iMEMORY_MASK;
    assign oMEM_RW    = iMEMORY_RW;
    assign oMEM_ADDR  = iMEMORY_ADDR;
    assign oMEM_DATA  = iMEMORY_DATA;
    assign oMEM_LOCK  = iMEMORY_LOCK;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Mailbox reads wait in DRAIN so downstream read data keeps its order.
    always_comb begin
        state_nxt     = state;
        oMEMORY_LOCK  = 1'b1;
        oMEMORY_VALID = iMEM_VALID;
        oMEMORY_DATA  = iMEM_DATA;
        oMEM_REQ      = 1'b0;
        case (state)
            ST_IDLE: begin
                oMEMORY_LOCK = iMEM_LOCK || full_c;
                // Hold the copy back while full so memory never takes a read the core retries.
                oMEM_REQ     = iMEMORY_REQ && !hit && !full_c;
                if (iMEMORY_REQ && !oMEMORY_LOCK && hit && !iMEMORY_RW) begin
                    state_nxt = (count != '0) ? ST_DRAIN : ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (count == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                oMEMORY_VALID = 1'b1;
                oMEMORY_DATA  = mbx_rdata;
                if (!iMEMORY_LOCK) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Responses arriving after a reset are forwarded; the counter floors at zero.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            count <= '0;
        end else begin
            case ({ds_read, iMEM_VALID})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   if (count != '0) count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            rd_idx <= '0;
        end else if (mbx_rd) begin
            rd_idx <= iMEMORY_ADDR[4:2];
        end
    end

    sim_mailbox_regfile u_regfile (
        .clk        (iCLOCK),
        .rst        (iRESET_SYNC),
        .wr_en      (mbx_wr),
        .wr_word    (iMEMORY_ORDER == ORDER_WORD),
        .wr_idx     (iMEMORY_ADDR[4:2]),
        .wr_data    (iMEMORY_DATA),
        .rd_idx     (rd_idx),
        .rd_data_c  (mbx_rdata),
        .done       (oMBX_DONE),
        .pass       (oMBX_PASS),
        .bus_err    (oMBX_BUS_ERR),
        .type_reg   (oMBX_TYPE),
        .index_reg  (oMBX_INDEX),
        .result_reg (oMBX_RESULT),
        .expect_reg (oMBX_EXPECT)
    );

endmodule

// File: tb/tb_sim_mailbox_bus_splitter.sv
// Scoreboard bench for the mailbox bus splitter: expected read data is queued
// as stimulus is driven and compared whenever a response is delivered.
module tb_sim_mailbox_bus_splitter;

    localparam logic [31:0] MBX = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        core_lock_out;
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        valid;
    logic        core_lock;
    logic [63:0] rdata;
    logic        mem_req;
    logic [1:0]  mem_order;
    logic [3:0]  mem_mask;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_lock;
    logic        mem_valid;
    logic        mem_lock_out;
    logic [63:0] mem_rdata;
    logic        mbx_done;
    logic        mbx_pass;
    logic [31:0] mbx_type;
    logic [31:0] mbx_index;
    logic [31:0] mbx_result;
    logic [31:0] mbx_expect;
    logic        mbx_bus_err;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    sim_mailbox_bus_splitter dut (
        .iCLOCK        (clk),
        .iRESET_SYNC   (rst),
        .iMEMORY_REQ   (req),
        .oMEMORY_LOCK  (core_lock_out),
        .iMEMORY_ORDER (order),
        .iMEMORY_MASK  (mask),
        .iMEMORY_RW    (rw),
        .iMEMORY_ADDR  (addr),
        .iMEMORY_DATA  (wdata),
        .oMEMORY_VALID (valid),
        .iMEMORY_LOCK  (core_lock),
        .oMEMORY_DATA  (rdata),
        .oMEM_REQ      (mem_req),
        .oMEM_ORDER    (mem_order),
        .oMEM_MASK     (mem_mask),
        .oMEM_RW       (mem_rw),
        .oMEM_ADDR     (mem_addr),
        .oMEM_DATA     (mem_wdata),
        .iMEM_LOCK     (mem_lock),
        .iMEM_VALID    (mem_valid),
        .oMEM_LOCK     (mem_lock_out),
        .iMEM_DATA     (mem_rdata),
        .oMBX_DONE     (mbx_done),
        .oMBX_PASS     (mbx_pass),
        .oMBX_TYPE     (mbx_type),
        .oMBX_INDEX    (mbx_index),
        .oMBX_RESULT   (mbx_result),
        .oMBX_EXPECT   (mbx_expect),
        .oMBX_BUS_ERR  (mbx_bus_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Delivered responses are popped from the scoreboard in order.
    always @(negedge clk) begin
        if (valid === 1'b1 && core_lock === 1'b0) begin
            if (exp_q.size() == 0) check("sb_unexpected", 64'(valid), 64'd0);
            else                   check("sb_data", rdata, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic bus_req(input logic r_w, input logic [1:0] ord, input logic [31:0] a,
                           input logic [31:0] d);
        int  n = 0;
        logic is_hit = (a[31:5] == MBX[31:5]);
        req = 1'b1; rw = r_w; order = ord; addr = a; wdata = d; mask = 4'hF;
        @(negedge clk);
        while (core_lock_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", 64'(core_lock_out), 64'd0);
        check("mem_req", 64'(mem_req), 64'(!is_hit));
        if (!is_hit) check("mem_addr", 64'(mem_addr), 64'(a));
        step();
        req = 1'b0;
    endtask

    task automatic mem_return(input logic [63:0] d);
        mem_valid = 1'b1;
        mem_rdata = d;
        exp_q.push_back(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req = 1'b0; order = 2'b10; mask = 4'hF; rw = 1'b0; addr = '0;
        wdata = '0; core_lock = 1'b0; mem_lock = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        step();
        do_reset();

        @(negedge clk);
        check("rst_done", 64'(mbx_done), 64'd0);
        check("rst_pass", 64'(mbx_pass), 64'd0);
        check("rst_err", 64'(mbx_bus_err), 64'd0);
        check("rst_type", 64'(mbx_type), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_lock", 64'(core_lock_out), 64'd0);

        // Pass-through read.
        step();
        bus_req(1'b0, 2'b10, 32'h0000_0100, 32'h0);
        mem_return(64'h1122_3344_5566_7788);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        check("pt_no_mbx", 64'(mbx_index), 64'd0);

        // Flag set, then finish: pass.
        step();
        bus_req(1'b1, 2'b10, MBX + 32'h00, 32'h0100_0000);
        bus_req(1'b1, 2'b10, MBX + 32'h04, 32'h0);
        @(negedge clk);
        check("fin_done", 64'(mbx_done), 64'd1);
        check("fin_pass", 64'(mbx_pass), 64'd1);
        step();
        exp_q.push_back({2{32'h0000_0001}});
        bus_req(1'b0, 2'b10, MBX + 32'h04, 32'h0);
        @(negedge clk);
        check("rd_lat_finish", 64'(valid), 64'd1);
        step();
        exp_q.push_back({2{32'h0100_0000}});
        bus_req(1'b0, 2'b10, MBX + 32'h00, 32'h0);
        step();
        bus_req(1'b1, 2'b10, MBX + 32'h08, 32'h4433_2211);
        @(negedge clk);
        check("after_done_ignored", 64'(mbx_type), 64'd0);

        // Register writes, flag 0, finish: fail.
        step();
        do_reset();
        bus_req(1'b1, 2'b10, MBX + 32'h0C, 32'h0500_0000);
        bus_req(1'b1, 2'b10, MBX + 32'h14, 32'hEFBE_ADDE);
        bus_req(1'b1, 2'b10, MBX + 32'h10, 32'h7856_3412);
        bus_req(1'b1, 2'b10, MBX + 32'h00, 32'h0);
        bus_req(1'b1, 2'b10, MBX + 32'h04, 32'h0);
        @(negedge clk);
        check("index", 64'(mbx_index), 64'h5);
        check("expect", 64'(mbx_expect), 64'hDEAD_BEEF);
        check("result", 64'(mbx_result), 64'h1234_5678);
        check("fail_pass", 64'(mbx_pass), 64'd0);
        check("fail_done", 64'(mbx_done), 64'd1);

        // Fill the outstanding window.
        step();
        for (int i = 0; i < 4; i++) bus_req(1'b0, 2'b10, 32'h0000_0200 + 32'(i * 4), 32'h0);
        req = 1'b1; rw = 1'b0; addr = 32'h0000_0210;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_lock", 64'(core_lock_out), 64'd1);
            step();
        end
        mem_return(64'hA000_0000_0000_0001);
        @(negedge clk);
        check("full_lock_on_ret", 64'(core_lock_out), 64'd1);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        check("unlock", 64'(core_lock_out), 64'd0);
        step();
        req = 1'b0;
        mem_return(64'hA000_0000_0000_0002);
        step();
        mem_valid = 1'b0;

        // Mailbox read behind three outstanding reads.
        bus_req(1'b0, 2'b10, MBX + 32'h0C, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mem_return(64'hB000_0000_0000_0000 + 64'(i));
            @(negedge clk);
            check("drain_lock", 64'(core_lock_out), 64'd1);
            step();
        end
        mem_valid = 1'b0;
        exp_q.push_back({2{32'h0500_0000}});
        @(negedge clk);
        check("drain_last_valid", 64'(valid), 64'd0);
        check("drain_last_lock", 64'(core_lock_out), 64'd1);
        step();
        @(negedge clk);
        check("drain_resp", 64'(valid), 64'd1);

        // Core stalls the mailbox response for three cycles.
        step();
        core_lock = 1'b1;
        bus_req(1'b0, 2'b10, MBX + 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(valid), 64'd1);
            check("hold_data", rdata, {2{32'h7856_3412}});
            step();
        end
        exp_q.push_back({2{32'h7856_3412}});
        core_lock = 1'b0;
        step();
        @(negedge clk);
        check("hold_idle_valid", 64'(valid), 64'd0);
        check("hold_idle_lock", 64'(core_lock_out), 64'd0);

        // Non-word mailbox write.
        step();
        do_reset();
        bus_req(1'b1, 2'b10, MBX + 32'h08, 32'hAABB_CCDD);
        bus_req(1'b1, 2'b00, MBX + 32'h08, 32'h1234_5678);
        @(negedge clk);
        check("bus_err", 64'(mbx_bus_err), 64'd1);
        check("type_kept", 64'(mbx_type), 64'hDDCC_BBAA);
        check("err_no_done", 64'(mbx_done), 64'd0);
        step();
        do_reset();
        @(negedge clk);
        check("rst2_err", 64'(mbx_bus_err), 64'd0);
        check("rst2_type", 64'(mbx_type), 64'd0);
        check("rst2_done", 64'(mbx_done), 64'd0);

        // Reset with a read in flight; late response must not underflow the count.
        step();
        bus_req(1'b0, 2'b10, 32'h0000_0300, 32'h0);
        do_reset();
        mem_return(64'hC0DE_0000_0000_0300);
        step();
        mem_valid = 1'b0;
        exp_q.push_back(64'd0);
        bus_req(1'b0, 2'b10, MBX + 32'h00, 32'h0);
        @(negedge clk);
        check("post_rst_lat", 64'(valid), 64'd1);
        step();
        step();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
